alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
Sequential front-end for the 8-bit ALU datapath. It accepts one operation per valid/ready command handshake, evaluates it, and holds the registered result and flags until a consumer accepts them on a second valid/ready handshake. Single-cycle ops (NOT, AND, OR, XOR, ADD, SUB, SHL) and a multi-cycle shift-add multiply share one controller, so the datapath sits between the instruction/control logic and the register writeback.

Parameters:
WIDTH, 8, operand/result width in bits. Fixed at 8 for this revision.
MUL_CYCLES, 8, multiply iterations. Must equal WIDTH.

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command; high only in IDLE
cmd_op  input  3  000 NOT A, 001 AND, 010 OR, 011 XOR, 100 ADD, 101 SUB, 110 SHL A, 111 MUL
cmd_a  input  8  operand A
cmd_b  input  8  operand B; ignored for NOT and SHL
res_valid  output  1  result/flags valid; high only in DONE
res_ready  input  1  consumer accepts result
res_data  output  8  registered result
res_carry  output  1  carry/borrow/overflow flag
res_zero  output  1  1 when res_data == 0
busy  output  1  high in MUL state

Behaviour:
- Clocking: one clock (clk). Reset is synchronous and active-high (rst). rst has priority over every other input.
- Reset values: state=IDLE, cmd_ready=1, res_valid=0, res_data=0, res_carry=0, res_zero=0, busy=0, internal accumulator=0, counter=0.
- States:
  - IDLE: cmd_ready=1.
  - MUL: busy=1, cmd_ready=0.
  - DONE: res_valid=1, cmd_ready=0.
- Command accept: cmd_valid && cmd_ready at edge N.
  - Non-MUL op: result and flags computed from cmd_* and registered at edge N; state becomes DONE. res_valid=1 after edge N (latency 1).
  - MUL: A and B latched; 16-bit accumulator cleared; counter=0; state becomes MUL.
- Result arithmetic (8-bit, wraps modulo 256):
  - NOT: ~A, carry=0.
  - AND / OR / XOR: carry=0.
  - ADD: A+B; carry = bit 8 of the 9-bit sum.
  - SUB: A-B; carry = borrow, i.e. 1 iff A<B unsigned.
  - SHL: {A[6:0],0}; carry = A[7].
  - MUL: low byte of A*B unsigned; carry = 1 iff high byte != 0.
- MUL iteration: each MUL-state edge, if B_latched[counter] then acc += A_latched << counter; counter++.
  - On the edge where counter==7: write res_data=final acc[7:0], res_carry=|acc[15:8], res_zero; go to DONE.
  - res_valid is high after edge N+8 (8 MUL cycles).
- res_zero is always computed from the value written to res_data.
- Result handshake: in DONE, res_data/res_carry/res_zero are held stable until res_valid && res_ready.
  - At that edge: state goes to IDLE, res_valid=0. res_data and flags keep their last value.
  - cmd_ready rises the following cycle; no same-cycle result-accept plus new command.
- Boundaries:
  - cmd_valid while not in IDLE: ignored, no effect.
  - res_ready while not in DONE: ignored.
  - res_ready held high permanently: one result per command, DONE lasts exactly 1 cycle.
  - rst during MUL or DONE: abandons the operation and produces all reset values next cycle; the pending result is lost.
  - counter wrap is not possible; counter is cleared on every MUL accept.
  - Operand changes after accept have no effect on the result.

Test Plan:
- Reset: assert rst 2 cycles with random inputs -> cmd_ready=1, res_valid=0, res_data=0x00, busy=0.
- Single-cycle ops: accept ADD A=0xF0 B=0x20 -> next cycle res_valid=1, res_data=0x10, carry=1, zero=0. SUB 0x05-0x05 -> 0x00, carry=0, zero=1. SUB 0x03-0x04 -> 0xFF, carry=1. NOT 0xA5 -> 0x5A. SHL 0x81 -> 0x02, carry=1.
- MUL latency and value: accept MUL A=0x10 B=0x10 at edge N -> busy=1 for 8 cycles, res_valid=1 after edge N+8, res_data=0x00, carry=1, zero=1. MUL 0x0F*0x03 -> 0x2D, carry=0.
- Backpressure: hold res_ready=0 for 5 cycles after result -> res_data/flags stable, cmd_ready=0, new cmd_valid ignored. Raise res_ready -> IDLE next edge, cmd_ready=1 one cycle later.
- Reset mid-MUL: assert rst at MUL cycle 4 -> IDLE, res_valid never asserts for that command. A subsequent AND 0xCC&0x0F -> 0x0C.
- Operand hold-off: change cmd_a/cmd_b during MUL -> result matches the latched operands.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Sequential front-end for the 8-bit ALU datapath. It takes one command per
//   cmd valid/ready handshake and evaluates it. Single-cycle ops are NOT, AND,
//   OR, XOR, ADD, SUB and SHL. MUL is a multi-cycle shift-add multiply. The
//   registered result and flags are held until the consumer accepts them on
//   the res valid/ready handshake.
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst        synchronous reset, active high, overrides every other input
//   i_cmd_valid  command present
//   o_cmd_ready  command can be accepted (IDLE only)
//   i_cmd_op     000 NOT, 001 AND, 010 OR, 011 XOR, 100 ADD, 101 SUB, 110 SHL, 111 MUL
//   i_cmd_a      operand A
//   i_cmd_b      operand B (ignored for NOT / SHL)
//   o_res_valid  result valid (DONE only)
//   i_res_ready  consumer accepts result
//   o_res_data   registered result
//   o_res_carry  carry / borrow / multiply-overflow flag
//   o_res_zero   result is zero
//   o_busy       multiply in progress
module alu_cmd_sequencer #(
    parameter int WIDTH      = 8,
    parameter int MUL_CYCLES = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [2:0]       i_cmd_op,
    input  logic [WIDTH-1:0] i_cmd_a,
    input  logic [WIDTH-1:0] i_cmd_b,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [WIDTH-1:0] o_res_data,
    output logic             o_res_carry,
    output logic             o_res_zero,
    output logic             o_busy
);

    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MUL_CYCLES - 1);

    localparam logic [2:0] OP_NOT = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                 r_state;
    state_e                 w_state_next;
    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic [2*WIDTH-1:0]     r_acc;
    logic [CW-1:0]          r_cnt;
    logic [WIDTH-1:0]       r_data;
    logic                   r_carry;
    logic                   r_zero;

    logic                   w_accept;
    logic                   w_is_mul;
    logic                   w_mul_last;
    logic [WIDTH:0]         w_sum;
    logic [WIDTH:0]         w_diff;
    logic [WIDTH-1:0]       w_alu_res;
    logic                   w_alu_carry;
    logic [2*WIDTH-1:0]     w_partial;
    logic [2*WIDTH-1:0]     w_acc_next;

    assign o_cmd_ready = (r_state == ST_IDLE);
    assign o_res_valid = (r_state == ST_DONE);
    assign o_busy      = (r_state == ST_MUL);
    assign o_res_data  = r_data;
    assign o_res_carry = r_carry;
    assign o_res_zero  = r_zero;

    assign w_accept   = i_cmd_valid && o_cmd_ready;
    assign w_is_mul   = (i_cmd_op == OP_MUL);
    assign w_mul_last = (r_cnt == CNT_LAST);

    // Bit 8 of the 9-bit difference is the borrow, so it is set exactly when A < B.
    assign w_sum  = {1'b0, i_cmd_a} + {1'b0, i_cmd_b};
    assign w_diff = {1'b0, i_cmd_a} - {1'b0, i_cmd_b};

    always_comb begin
        w_alu_res   = '0;
        w_alu_carry = 1'b0;
        case (i_cmd_op)
            OP_NOT: w_alu_res = ~i_cmd_a;
            OP_AND: w_alu_res = i_cmd_a & i_cmd_b;
            OP_OR:  w_alu_res = i_cmd_a | i_cmd_b;
            OP_XOR: w_alu_res = i_cmd_a ^ i_cmd_b;
            OP_ADD: begin
                w_alu_res   = w_sum[WIDTH-1:0];
                w_alu_carry = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_alu_res   = w_diff[WIDTH-1:0];
                w_alu_carry = w_diff[WIDTH];
            end
            OP_SHL: begin
                w_alu_res   = {i_cmd_a[WIDTH-2:0], 1'b0};
                w_alu_carry = i_cmd_a[WIDTH-1];
            end
            default: ;
        endcase
    end

    // One shift-add step. The final step's sum is written straight to the
    // result so that DONE is reached on the MUL_CYCLES-th MUL edge.
    assign w_partial  = {{WIDTH{1'b0}}, r_a} << r_cnt;
    assign w_acc_next = r_acc + (r_b[r_cnt] ? w_partial : '0);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (i_cmd_valid) w_state_next = w_is_mul ? ST_MUL : ST_DONE;
            ST_MUL:  if (w_mul_last)  w_state_next = ST_DONE;
            ST_DONE: if (i_res_ready) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_accept) begin
            if (w_is_mul) begin
                r_a   <= i_cmd_a;
                r_b   <= i_cmd_b;
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_data  <= w_alu_res;
                r_carry <= w_alu_carry;
                r_zero  <= (w_alu_res == '0);
            end
        end else if (r_state == ST_MUL) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 1'b1;
            if (w_mul_last) begin
                r_data  <= w_acc_next[WIDTH-1:0];
                r_carry <= |w_acc_next[2*WIDTH-1:WIDTH];
                r_zero  <= (w_acc_next[WIDTH-1:0] == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: directed and randomized commands checked
// against an arithmetic reference model of each operation.
module tb_alu_cmd_sequencer;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_carry;
    logic       res_zero;
    logic       busy;

    int n_pass  = 0;
    int n_total = 0;

    alu_cmd_sequencer #(.WIDTH(8), .MUL_CYCLES(8)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_op    (cmd_op),
        .i_cmd_a     (cmd_a),
        .i_cmd_b     (cmd_b),
        .o_res_valid (res_valid),
        .i_res_ready (res_ready),
        .o_res_data  (res_data),
        .o_res_carry (res_carry),
        .o_res_zero  (res_zero),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: returns {carry, zero, data}
    function automatic logic [9:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int unsigned r;
        logic        c;
        logic [7:0]  d;
        c = 1'b0;
        case (op)
            3'd0: r = 255 - a;
            3'd1: r = a & b;
            3'd2: r = a | b;
            3'd3: r = a ^ b;
            3'd4: begin r = a + b; c = (r > 255); end
            3'd5: begin c = (a < b); r = (a + 256 - b) % 256; end
            3'd6: begin r = (a * 2) % 256; c = (a >= 128); end
            default: begin r = a * b; c = (r > 255); end
        endcase
        d = 8'(r % 256);
        return {c, (d == 8'h00), d};
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input bit hold_ready, input string name);
        logic [9:0] exp;
        exp = model(op, a, b);
        n_total++;
        if (cmd_ready !== 1'b1) $display("FAIL %s pre_ready: got %b want 1", name, cmd_ready);
        else n_pass++;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1; res_ready = hold_ready;
        step();
        cmd_valid = 1'b0;
        cmd_a = 8'($urandom); cmd_b = 8'($urandom);
        if (op == 3'd7) begin
            for (int i = 0; i < 8; i++) begin
                n_total++;
                if ({busy, res_valid, cmd_ready} !== 3'b100)
                    $display("FAIL %s mul_cycle%0d busy/valid/ready: got %b want 100", name, i, {busy, res_valid, cmd_ready});
                else n_pass++;
                // commands and res_ready outside DONE must be ignored
                cmd_valid = 1'($urandom); cmd_op = 3'($urandom);
                cmd_a = 8'($urandom); cmd_b = 8'($urandom);
                res_ready = hold_ready ? 1'b1 : 1'($urandom);
                if (i == 7) begin cmd_valid = 1'b0; res_ready = hold_ready; end
                step();
            end
        end
        n_total++;
        if ({res_valid, busy, cmd_ready, res_carry, res_zero, res_data} !== {3'b100, exp})
            $display("FAIL %s result: got v=%b b=%b r=%b c=%b z=%b d=%h want v=1 b=0 r=0 c=%b z=%b d=%h",
                     name, res_valid, busy, cmd_ready, res_carry, res_zero, res_data, exp[9], exp[8], exp[7:0]);
        else n_pass++;
        res_ready = 1'b1;
        step();
        n_total++;
        if ({res_valid, cmd_ready, res_carry, res_zero, res_data} !== {2'b01, exp})
            $display("FAIL %s after_accept: got v=%b r=%b c=%b z=%b d=%h want v=0 r=1 held %h",
                     name, res_valid, cmd_ready, res_carry, res_zero, res_data, exp);
        else n_pass++;
        res_ready = hold_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cmd_valid = 1'($urandom); cmd_op = 3'($urandom);
            cmd_a = 8'($urandom); cmd_b = 8'($urandom); res_ready = 1'($urandom);
            step();
            n_total++;
            if ({cmd_ready, res_valid, busy, res_carry, res_zero, res_data} !== 13'b1_0000_0000_0000)
                $display("FAIL reset%0d: got r=%b v=%b b=%b c=%b z=%b d=%h want r=1 others 0",
                         i, cmd_ready, res_valid, busy, res_carry, res_zero, res_data);
            else n_pass++;
        end
        rst = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
    endtask

    task automatic test_single_cycle();
        run_op(3'd4, 8'hF0, 8'h20, 1'b0, "add_carry");
        run_op(3'd5, 8'h05, 8'h05, 1'b0, "sub_zero");
        run_op(3'd5, 8'h03, 8'h04, 1'b0, "sub_borrow");
        run_op(3'd0, 8'hA5, 8'h00, 1'b0, "not");
        run_op(3'd6, 8'h81, 8'h33, 1'b0, "shl_carry");
        run_op(3'd1, 8'hCC, 8'h0F, 1'b0, "and");
        run_op(3'd2, 8'hC0, 8'h0F, 1'b0, "or");
        run_op(3'd3, 8'hFF, 8'hFF, 1'b0, "xor_zero");
        for (int i = 0; i < 20; i++)
            run_op(3'($urandom_range(0, 6)), 8'($urandom), 8'($urandom), 1'b0, "rand_single");
    endtask

    task automatic test_mul();
        run_op(3'd7, 8'h10, 8'h10, 1'b0, "mul_overflow");
        run_op(3'd7, 8'h0F, 8'h03, 1'b0, "mul_small");
        run_op(3'd7, 8'hFF, 8'hFF, 1'b0, "mul_max");
        run_op(3'd7, 8'h00, 8'h7B, 1'b0, "mul_zero");
        for (int i = 0; i < 8; i++)
            run_op(3'd7, 8'($urandom), 8'($urandom), 1'b0, "rand_mul");
    endtask

    task automatic test_backpressure();
        logic [9:0] exp;
        exp = model(3'd4, 8'h7F, 8'h01);
        cmd_op = 3'd4; cmd_a = 8'h7F; cmd_b = 8'h01; cmd_valid = 1'b1; res_ready = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_op = 3'($urandom); cmd_a = 8'($urandom); cmd_b = 8'($urandom);
            n_total++;
            if ({res_valid, cmd_ready, res_carry, res_zero, res_data} !== {2'b10, exp})
                $display("FAIL bp_hold%0d: got v=%b r=%b c=%b z=%b d=%h want v=1 r=0 %h",
                         i, res_valid, cmd_ready, res_carry, res_zero, res_data, exp);
            else n_pass++;
            step();
        end
        cmd_valid = 1'b0; res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        n_total++;
        if ({res_valid, cmd_ready, res_carry, res_zero, res_data} !== {2'b01, exp})
            $display("FAIL bp_release: got v=%b r=%b d=%h want v=0 r=1 %h",
                     res_valid, cmd_ready, res_data, exp[7:0]);
        else n_pass++;
    endtask

    task automatic test_reset_mid_mul();
        bit seen_valid;
        cmd_op = 3'd7; cmd_a = 8'h37; cmd_b = 8'h5D; cmd_valid = 1'b1; res_ready = 1'b1;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_total++;
        if ({cmd_ready, res_valid, busy, res_carry, res_zero, res_data} !== 13'b1_0000_0000_0000)
            $display("FAIL rst_mid_mul: got r=%b v=%b b=%b c=%b z=%b d=%h want r=1 others 0",
                     cmd_ready, res_valid, busy, res_carry, res_zero, res_data);
        else n_pass++;
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (res_valid === 1'b1 || busy === 1'b1) seen_valid = 1'b1;
            step();
        end
        n_total++;
        if (seen_valid !== 1'b0) $display("FAIL rst_mid_mul_ghost: got activity=%b want 0", seen_valid);
        else n_pass++;
        res_ready = 1'b0;
        run_op(3'd1, 8'hCC, 8'h0F, 1'b0, "and_after_rst");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++)
            run_op(3'($urandom), 8'($urandom), 8'($urandom), 1'b1, "b2b");
        res_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; res_ready = 1'b0;
        test_reset();
        test_single_cycle();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
